// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one word read at a time to
// instruction memory and presents each fetched word to decode until accepted.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        stop
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_req_q, pc_req_d;
   logic [31:0] inst_data_q, inst_data_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        kill_q, kill_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] redir_tgt;

   assign redir_tgt = redirect_pc & ~32'h3;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_req_d     = pc_req_q;
      inst_data_d  = inst_data_q;
      inst_pc_d    = inst_pc_q;
      kill_d       = kill_q;
      inst_valid_d = inst_valid_q;
      case (state_q)
         S_REQ: begin
            if (imem_req_ready) begin
               state_d  = S_WAIT;
               pc_req_d = pc_q;
               // a request accepted alongside a redirect is already stale
               if (redirect_valid) begin
                  kill_d = 1'b1;
                  pc_d   = redir_tgt;
               end
            end else if (redirect_valid) begin
               pc_d = redir_tgt;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_d = redir_tgt;
               if (imem_rsp_valid) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  kill_d = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  inst_data_d  = imem_rsp_data;
                  inst_pc_d    = pc_req_q;
                  inst_valid_d = 1'b1;
                  pc_d         = pc_req_q + 32'd4;
                  state_d      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               inst_valid_d = 1'b0;
               pc_d         = redir_tgt;
               state_d      = S_REQ;
            end else if (inst_ready) begin
               inst_valid_d = 1'b0;
               state_d      = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         pc_req_q     <= 32'h0;
         inst_data_q  <= 32'h0;
         inst_pc_q    <= 32'h0;
         kill_q       <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_req_q     <= pc_req_d;
         inst_data_q  <= inst_data_d;
         inst_pc_q    <= inst_pc_d;
         kill_q       <= kill_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_addr      = pc_q;
   assign inst_valid     = inst_valid_q;
   assign inst_data      = inst_data_q;
   assign inst_pc        = inst_pc_q;
   // only a live, unredirected response lets the PC step forward
   assign stop = ~((state_q == S_WAIT) & imem_rsp_valid & ~kill_q & ~redirect_valid);

endmodule
